// File: rtl/wifi_tx_multimode_mapper_if.sv
// wifi_tx_multimode_mapper_if: bit-stream input and symbol-stream output bundle of the TX mapper
//   valid_in/data_in/last_in : serial coded bits from the interleaver, last_in marks the frame's final bit
//   enable                   : downstream read enable (symbols pop only while high)
//   valid_out/mod_out_re/mod_out_im/last_sym : registered I/Q symbol toward the IFFT buffer
//   master = bit source / symbol sink side, slave = mapper side
interface wifi_tx_multimode_mapper_if #(parameter int OUT_W = 12);
    logic                    valid_in;
    logic                    data_in;
    logic                    last_in;
    logic                    enable;
    logic                    valid_out;
    logic signed [OUT_W-1:0] mod_out_re;
    logic signed [OUT_W-1:0] mod_out_im;
    logic                    last_sym;
    modport master (output valid_in, data_in, last_in, enable,
                    input  valid_out, mod_out_re, mod_out_im, last_sym);
    modport slave  (input  valid_in, data_in, last_in, enable,
                    output valid_out, mod_out_re, mod_out_im, last_sym);
endinterface

// File: rtl/wifi_tx_multimode_mapper.sv
// wifi_tx_multimode_mapper: bit FIFO plus run-time BPSK/QPSK/16QAM/64QAM Gray mapper (802.11a/g)
//   clk, reset (async, active-low)
//   mode       : 00 BPSK, 01 QPSK, 10 16QAM, 11 64QAM, latched when a frame starts
//   bus        : valid_in/data_in/last_in/enable in, valid_out/mod_out_re/mod_out_im/last_sym out
//   finished   : one-cycle pulse after the final symbol of a frame
//   re_out     : high in the cycle a symbol is popped from the FIFO
//   fifo_level : bits currently stored
//   overflow   : sticky, set when an incoming bit is dropped
//   sym_count  : symbols emitted in the current/last frame, present only with WIFI_TX_MAPPER_SYMCNT_EN
module wifi_tx_multimode_mapper #(
    parameter int DEPTH = 288,
    parameter int OUT_W = 12,
    parameter int LVL_W = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    wifi_tx_multimode_mapper_if.slave bus,
    output logic                  finished,
    output logic                  re_out,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  overflow
`ifdef WIFI_TX_MAPPER_SYMCNT_EN
    ,
    output logic [15:0]           sym_count
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [DEPTH-1:0]  mem;
    logic [LVL_W-1:0]  wptr, rptr;
    logic [1:0]        mode_q;
    logic              closed;
    logic [2:0]        nbpsc, take;
    logic              wr, pop, empt;
    logic [5:0]        b;
    logic signed [11:0] i12, q12;

    function automatic logic [LVL_W-1:0] wrap_add(logic [LVL_W-1:0] p, logic [2:0] n);
        logic [LVL_W:0] s;
        s = {1'b0, p} + (LVL_W+1)'(n);
        return s >= (LVL_W+1)'(DEPTH) ? LVL_W'(s - (LVL_W+1)'(DEPTH)) : s[LVL_W-1:0];
    endfunction

    function automatic logic signed [11:0] lvl2(logic [1:0] g);
        return g == 2'b00 ? -12'sd971 : g == 2'b01 ? -12'sd324 : g == 2'b11 ? 12'sd324 : 12'sd971;
    endfunction

    function automatic logic signed [11:0] lvl3(logic [2:0] g);
        case (g)
            3'b000:  return -12'sd1106;
            3'b001:  return -12'sd790;
            3'b011:  return -12'sd474;
            3'b010:  return -12'sd158;
            3'b110:  return 12'sd158;
            3'b111:  return 12'sd474;
            3'b101:  return 12'sd790;
            default: return 12'sd1106;
        endcase
    endfunction

    assign nbpsc = mode_q == 2'd0 ? 3'd1 : mode_q == 2'd1 ? 3'd2 : mode_q == 2'd2 ? 3'd4 : 3'd6;
    assign wr    = bus.valid_in && fifo_level != LVL_W'(DEPTH) && !closed;
    // real bits popped; a closed frame may hold fewer than one full symbol
    assign take  = fifo_level < LVL_W'(nbpsc) ? fifo_level[2:0] : nbpsc;
    assign pop   = state == RUN && bus.enable &&
                   (fifo_level >= LVL_W'(nbpsc) || (closed && fifo_level != '0));
    // writes are blocked once closed, so this pop drains the FIFO completely
    assign empt  = closed && fifo_level <= LVL_W'(nbpsc);
    assign re_out = pop;

    // b[0] is the oldest bit; positions beyond the stored bits are zero padding
    always_comb begin
        b = '0;
        for (int i = 0; i < 6; i++)
            b[i] = 3'(i) < take ? mem[wrap_add(rptr, 3'(i))] : 1'b0;
    end

    always_comb begin
        i12 = b[0] ? 12'sd1024 : -12'sd1024;
        q12 = '0;
        case (mode_q)
            2'd1: begin
                i12 = b[0] ? 12'sd724 : -12'sd724;
                q12 = b[1] ? 12'sd724 : -12'sd724;
            end
            2'd2: begin
                i12 = lvl2({b[0], b[1]});
                q12 = lvl2({b[2], b[3]});
            end
            2'd3: begin
                i12 = lvl3({b[0], b[1], b[2]});
                q12 = lvl3({b[3], b[4], b[5]});
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = wr ? RUN : IDLE;
            RUN:     state_nxt = pop && empt ? DONE : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (wr) mem[wptr] <= bus.data_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            wptr           <= '0;
            rptr           <= '0;
            fifo_level     <= '0;
            mode_q         <= '0;
            closed         <= 1'b0;
            overflow       <= 1'b0;
            finished       <= 1'b0;
            bus.valid_out  <= 1'b0;
            bus.last_sym   <= 1'b0;
            bus.mod_out_re <= '0;
            bus.mod_out_im <= '0;
`ifdef WIFI_TX_MAPPER_SYMCNT_EN
            sym_count      <= '0;
`endif
        end else begin
            state      <= state_nxt;
            fifo_level <= fifo_level + LVL_W'(wr) - (pop ? LVL_W'(take) : '0);
            if (wr) wptr <= wrap_add(wptr, 3'd1);
            if (pop) rptr <= wrap_add(rptr, take);
            if (state == IDLE && wr) mode_q <= mode;
            if (wr && bus.last_in) closed <= 1'b1;
            else if (state == DONE) closed <= 1'b0;
            if (bus.valid_in && !wr) overflow <= 1'b1;
            finished      <= state == DONE;
            bus.valid_out <= pop;
            bus.last_sym  <= pop && empt;
            if (pop) begin
                bus.mod_out_re <= OUT_W'(i12) <<< (OUT_W - 12);
                bus.mod_out_im <= OUT_W'(q12) <<< (OUT_W - 12);
            end
`ifdef WIFI_TX_MAPPER_SYMCNT_EN
            if (state == IDLE && wr) sym_count <= '0;
            else if (pop && sym_count != 16'hFFFF) sym_count <= sym_count + 16'd1;
`endif
        end
    end
endmodule

// File: tb/tb_wifi_tx_multimode_mapper.sv
// tb_wifi_tx_multimode_mapper: table-driven frame vectors plus directed overflow, wrap, reset and mode-latch sequences
module tb_wifi_tx_multimode_mapper;
    localparam int DEPTH = 288;
    localparam int OUT_W = 12;
    localparam int LVL_W = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             finished, re_out, overflow;
    logic [LVL_W-1:0] fifo_level;
`ifdef WIFI_TX_MAPPER_SYMCNT_EN
    logic [15:0]      sym_count;
`endif

    wifi_tx_multimode_mapper_if #(.OUT_W(OUT_W)) bus ();

    wifi_tx_multimode_mapper #(.DEPTH(DEPTH), .OUT_W(OUT_W), .LVL_W(LVL_W)) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .bus(bus.slave),
        .finished(finished),
        .re_out(re_out),
        .fifo_level(fifo_level),
        .overflow(overflow)
`ifdef WIFI_TX_MAPPER_SYMCNT_EN
        ,
        .sym_count(sym_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       mode;
        int               nbits;
        logic [7:0]       bits;
        int               nsym;
        logic [2:0][11:0] re;
        logic [2:0][11:0] im;
    } vec_t;

    vec_t vecs[8];
    int n_chk = 0, n_err = 0, cyc = 0;
    int fin_n, fin_cyc, last_cyc, re_n;
    logic signed [11:0] q_re[$], q_im[$];
    logic q_last[$];

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (bus.valid_out) begin
                q_re.push_back(bus.mod_out_re);
                q_im.push_back(bus.mod_out_im);
                q_last.push_back(bus.last_sym);
                if (bus.last_sym) last_cyc = cyc;
            end
            if (finished) begin
                fin_n++;
                fin_cyc = cyc;
            end
            if (re_out) re_n++;
        end
    end

    function automatic vec_t mk(logic [1:0] m, int nb, logic [7:0] bits, int ns,
                                int r0, int i0, int r1, int i1, int r2, int i2);
        vec_t v;
        v.mode = m; v.nbits = nb; v.bits = bits; v.nsym = ns;
        v.re[0] = 12'(r0); v.im[0] = 12'(i0);
        v.re[1] = 12'(r1); v.im[1] = 12'(i1);
        v.re[2] = 12'(r2); v.im[2] = 12'(i2);
        return v;
    endfunction

    task automatic chk(string nm, int got, int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.valid_in = 1'b0;
        bus.data_in  = 1'b0;
        bus.last_in  = 1'b0;
    endtask

    task automatic clear_mon();
        q_re.delete(); q_im.delete(); q_last.delete();
        fin_n = 0; re_n = 0; last_cyc = -10; fin_cyc = -20;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_in();
        tick();
        tick();
        reset = 1'b1;
        tick();
        clear_mon();
    endtask

    task automatic send(logic bit_v, logic last_v);
        bus.valid_in = 1'b1;
        bus.data_in  = bit_v;
        bus.last_in  = last_v;
        tick();
    endtask

    task automatic wait_fin(int lim);
        for (int i = 0; i < lim && fin_n == 0; i++) tick();
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int mism, bad, nlast;
        logic bq[$];
        logic bv;
        vecs[0] = mk(2'd1, 2, 8'b10,       1,   724,  -724,    0,     0,    0, 0);
        vecs[1] = mk(2'd2, 8, 8'b10010011, 2,   971,  -324, -971,   324,    0, 0);
        vecs[2] = mk(2'd3, 8, 8'b11100010, 2,   474, -1106, 1106, -1106,    0, 0);
        vecs[3] = mk(2'd0, 3, 8'b101,      3,  1024,     0, -1024,    0, 1024, 0);
        vecs[4] = mk(2'd3, 6, 8'b011010,   1,  -474,  -158,    0,     0,    0, 0);
        vecs[5] = mk(2'd3, 6, 8'b101001,   1,   790,  -790,    0,     0,    0, 0);
        vecs[6] = mk(2'd2, 2, 8'b11,       1,   324,  -971,    0,     0,    0, 0);
        vecs[7] = mk(2'd1, 4, 8'b0111,     2,  -724,   724,  724,   724,    0, 0);

        idle_in();
        bus.enable = 1'b0;
        tick();
        chk("rst_valid_out", int'(bus.valid_out), 0);
        chk("rst_re", int'(bus.mod_out_re), 0);
        chk("rst_im", int'(bus.mod_out_im), 0);
        chk("rst_last_sym", int'(bus.last_sym), 0);
        chk("rst_finished", int'(finished), 0);
        chk("rst_re_out", int'(re_out), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_overflow", int'(overflow), 0);
        reset = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            do_reset();
            mode = vecs[v].mode;
            bus.enable = 1'b1;
            for (int i = 0; i < vecs[v].nbits; i++)
                send(vecs[v].bits[vecs[v].nbits-1-i], i == vecs[v].nbits - 1);
            idle_in();
            wait_fin(40);
            chk($sformatf("v%0d_nsym", v), q_re.size(), vecs[v].nsym);
            for (int k = 0; k < vecs[v].nsym && k < q_re.size(); k++) begin
                chk($sformatf("v%0d_s%0d_re", v, k), int'(q_re[k]), int'($signed(vecs[v].re[k])));
                chk($sformatf("v%0d_s%0d_im", v, k), int'(q_im[k]), int'($signed(vecs[v].im[k])));
                chk($sformatf("v%0d_s%0d_last", v, k), int'(q_last[k]), int'(k == vecs[v].nsym - 1));
            end
            chk($sformatf("v%0d_fin_count", v), fin_n, 1);
            chk($sformatf("v%0d_fin_after_last", v), fin_cyc, last_cyc + 1);
            chk($sformatf("v%0d_level", v), int'(fifo_level), 0);
            chk($sformatf("v%0d_hold_valid", v), int'(bus.valid_out), 0);
            chk($sformatf("v%0d_hold_re", v), int'(bus.mod_out_re), int'($signed(vecs[v].re[vecs[v].nsym-1])));
        end

        // fill past capacity with reads stalled, then drain
        do_reset();
        mode = 2'd0;
        bus.enable = 1'b0;
        bq.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            bv = 1'($urandom_range(0, 1));
            if (i < DEPTH) bq.push_back(bv);
            send(bv, 1'b0);
        end
        idle_in();
        tick();
        chk("ovf_level_full", int'(fifo_level), DEPTH);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_no_output_stalled", q_re.size(), 0);
        chk("ovf_no_pop_stalled", re_n, 0);
        bus.enable = 1'b1;
        repeat (DEPTH + 10) tick();
        chk("ovf_drain_count", q_re.size(), DEPTH);
        chk("ovf_re_out_count", re_n, DEPTH);
        mism = 0;
        for (int k = 0; k < DEPTH && k < q_re.size(); k++)
            if (int'(q_re[k]) != (bq[k] ? 1024 : -1024) || q_im[k] != 0) mism++;
        chk("ovf_drain_data", mism, 0);
        chk("ovf_level_empty", int'(fifo_level), 0);
        chk("ovf_sticky", int'(overflow), 1);

        // steady write+pop across the pointer wrap
        do_reset();
        chk("wrap_overflow_cleared", int'(overflow), 0);
        mode = 2'd0;
        bus.enable = 1'b0;
        bq.delete();
        for (int i = 0; i < 5; i++) begin
            bv = 1'($urandom_range(0, 1));
            bq.push_back(bv);
            send(bv, 1'b0);
        end
        bus.enable = 1'b1;
        bad = 0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            if (fifo_level != LVL_W'(5)) bad++;
            bv = 1'($urandom_range(0, 1));
            bq.push_back(bv);
            send(bv, i == DEPTH + 19);
        end
        idle_in();
        wait_fin(20);
        chk("wrap_level_constant", bad, 0);
        chk("wrap_count", q_re.size(), DEPTH + 25);
        mism = 0;
        nlast = 0;
        for (int k = 0; k < bq.size() && k < q_re.size(); k++) begin
            if (int'(q_re[k]) != (bq[k] ? 1024 : -1024)) mism++;
            if (q_last[k]) nlast++;
        end
        chk("wrap_data_order", mism, 0);
        chk("wrap_last_count", nlast, 1);
        chk("wrap_last_position", int'(q_last.size() > 0 ? q_last[q_last.size()-1] : 1'b0), 1);
        chk("wrap_fin", fin_n, 1);
        chk("wrap_no_overflow", int'(overflow), 0);

        // mode is frozen once a frame starts
        do_reset();
        mode = 2'd1;
        bus.enable = 1'b1;
        send(1'b1, 1'b0);
        mode = 2'd3;
        send(1'b1, 1'b1);
        idle_in();
        wait_fin(20);
        chk("latch_nsym", q_re.size(), 1);
        chk("latch_re", q_re.size() > 0 ? int'(q_re[0]) : 0, 724);
        chk("latch_im", q_im.size() > 0 ? int'(q_im[0]) : 0, 724);
`ifdef WIFI_TX_MAPPER_SYMCNT_EN
        chk("latch_sym_count", int'(sym_count), 1);
`endif

        // reset in the middle of a frame
        do_reset();
        mode = 2'd3;
        bus.enable = 1'b1;
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        idle_in();
        for (int i = 0; i < 10 && !bus.valid_out; i++) tick();
        chk("mid_pre_valid", int'(bus.valid_out), 1);
        chk("mid_pre_re", int'(bus.mod_out_re), 474);
        reset = 1'b0;
        #1;
        chk("mid_valid_out", int'(bus.valid_out), 0);
        chk("mid_re", int'(bus.mod_out_re), 0);
        chk("mid_im", int'(bus.mod_out_im), 0);
        chk("mid_level", int'(fifo_level), 0);
        chk("mid_re_out", int'(re_out), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        clear_mon();
        mode = 2'd1;
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        idle_in();
        wait_fin(20);
        chk("post_rst_nsym", q_re.size(), 1);
        chk("post_rst_re", q_re.size() > 0 ? int'(q_re[0]) : 0, -724);
        chk("post_rst_im", q_im.size() > 0 ? int'(q_im[0]) : 0, 724);
        chk("post_rst_fin", fin_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
